// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared class enum, constants and stage payload types for fp_mult_round
// Optional feature macro: FP_ROUND_INEXACT_EN
package fp_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    ZERO   = 2'b01,
    INF    = 2'b10,
    NAN    = 2'b11
  } fp_class_t;

  localparam int          FP_BIAS    = 127;
  localparam int          FP_EXP_MAX = 255;
  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;

  // Normalized beat waiting for rounding; the exponent is kept beside it
  // because its width is a module parameter.
  typedef struct packed {
    logic        sign;
    fp_class_t   cls;
    logic [22:0] frac;
    logic        guard;
    logic        sticky;
`ifdef FP_ROUND_INEXACT_EN
    logic        mant_nz;
`endif
  } s1_t;

  // Final packed result and flags as presented on the output port.
  typedef struct packed {
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        exception;
`ifdef FP_ROUND_INEXACT_EN
    logic        inexact;
`endif
  } s2_t;

endpackage

// File: rtl/fp_mult_round_if.sv
// rtl/fp_mult_round_if.sv - input/output handshake bundle (FP_ROUND_INEXACT_EN adds out_inexact)
interface fp_mult_round_if #(
  parameter int EXP_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [47:0]      in_mant;
  logic [1:0]       in_class;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic             out_overflow;
  logic             out_underflow;
  logic             out_exception;
`ifdef FP_ROUND_INEXACT_EN
  logic             out_inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_class, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow,
           out_exception, out_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_class, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow,
           out_exception, out_inexact
  );
`else
  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_class, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow,
           out_exception
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_class, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow,
           out_exception
  );
`endif
endinterface

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - combinational round-to-nearest-even of a 23-bit fraction (FP_ROUND_INEXACT_EN adds inexact_o)
module fp_round_rne #(
  parameter int EXP_W = 10
) (
  input  logic [22:0]             frac_i,
  input  logic                    guard_i,
  input  logic                    sticky_i,
  input  logic signed [EXP_W-1:0] exp_i,
  output logic [22:0]             frac_o,
`ifdef FP_ROUND_INEXACT_EN
  output logic                    inexact_o,
`endif
  output logic signed [EXP_W-1:0] exp_o
);

  logic        round_up;
  logic [23:0] sum;

  // Ties go to the even fraction; a carry out of the fraction bumps the exponent.
  always_comb begin
    round_up = guard_i & (sticky_i | frac_i[0]);
    sum      = {1'b0, frac_i} + {23'd0, round_up};
    frac_o   = sum[23] ? 23'd0 : sum[22:0];
    exp_o    = exp_i + {{(EXP_W-1){1'b0}}, sum[23]};
`ifdef FP_ROUND_INEXACT_EN
    inexact_o = guard_i | sticky_i;
`endif
  end

endmodule

// File: rtl/fp_mult_round.sv
// rtl/fp_mult_round.sv - two-stage normalize/round pipeline for the binary32 multiplier (FP_ROUND_INEXACT_EN enables out_inexact)
module fp_mult_round
  import fp_pkg::*;
#(
  parameter int EXP_W = 10
) (
  input  logic            clk,
  input  logic            rst,
  fp_mult_round_if.slave  bus
);

  localparam logic signed [EXP_W-1:0] EXP_ONE   = EXP_W'(1);
  localparam logic signed [EXP_W-1:0] EXP_MAX_S = EXP_W'(FP_EXP_MAX);
  localparam logic signed [EXP_W-1:0] EXP_ZERO  = '0;

  logic                    s1_valid_q, s1_valid_d;
  s1_t                     s1_q, s1_d;
  logic signed [EXP_W-1:0] s1_exp_q, s1_exp_d;
  logic                    s2_valid_q, s2_valid_d;
  s2_t                     s2_q, s2_d;

  logic                    s2_advance;
  logic                    in_fire;
  logic signed [EXP_W-1:0] in_exp_s;
  logic [22:0]             rnd_frac;
  logic signed [EXP_W-1:0] rnd_exp;
`ifdef FP_ROUND_INEXACT_EN
  logic                    rnd_inexact;
`endif

  // Stage 2 can take a new beat when it is empty or its beat leaves this cycle.
  assign s2_advance   = !s2_valid_q | bus.out_ready;
  assign bus.in_ready = !s1_valid_q | s2_advance;
  assign in_fire      = bus.in_valid & bus.in_ready;
  assign in_exp_s     = $signed(bus.in_exp);

  fp_round_rne #(.EXP_W(EXP_W)) u_round (
    .frac_i    (s1_q.frac),
    .guard_i   (s1_q.guard),
    .sticky_i  (s1_q.sticky),
    .exp_i     (s1_exp_q),
    .frac_o    (rnd_frac),
`ifdef FP_ROUND_INEXACT_EN
    .inexact_o (rnd_inexact),
`endif
    .exp_o     (rnd_exp)
  );

  // Stage 1: align the product so the leading one is implicit, split off guard/sticky.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s1_exp_d   = s1_exp_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_d.sign  = bus.in_sign;
      s1_d.cls   = fp_class_t'(bus.in_class);
      if (bus.in_mant[47]) begin
        s1_d.frac   = bus.in_mant[46:24];
        s1_d.guard  = bus.in_mant[23];
        s1_d.sticky = |bus.in_mant[22:0];
        s1_exp_d    = in_exp_s + EXP_ONE;
      end else begin
        s1_d.frac   = bus.in_mant[45:23];
        s1_d.guard  = bus.in_mant[22];
        s1_d.sticky = |bus.in_mant[21:0];
        s1_exp_d    = in_exp_s;
      end
`ifdef FP_ROUND_INEXACT_EN
      s1_d.mant_nz = |bus.in_mant;
`endif
    end else if (s2_advance) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2: apply class overrides, else range-check the rounded exponent and pack.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (s2_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_d = '0;
        case (s1_q.cls)
          ZERO: s2_d.result = {s1_q.sign, 31'd0};
          INF: begin
            s2_d.result    = {s1_q.sign, 8'hFF, 23'd0};
            s2_d.exception = 1'b1;
          end
          NAN: begin
            s2_d.result    = FP_QNAN;
            s2_d.exception = 1'b1;
          end
          default: begin
            if (rnd_exp >= EXP_MAX_S) begin
              s2_d.result   = {s1_q.sign, 8'hFF, 23'd0};
              s2_d.overflow = 1'b1;
`ifdef FP_ROUND_INEXACT_EN
              s2_d.inexact  = 1'b1;
`endif
            end else if (rnd_exp <= EXP_ZERO) begin
              s2_d.result    = {s1_q.sign, 31'd0};
              s2_d.underflow = 1'b1;
`ifdef FP_ROUND_INEXACT_EN
              s2_d.inexact   = s1_q.mant_nz;
`endif
            end else begin
              s2_d.result  = {s1_q.sign, rnd_exp[7:0], rnd_frac};
`ifdef FP_ROUND_INEXACT_EN
              s2_d.inexact = rnd_inexact;
`endif
            end
          end
        endcase
      end
    end
  end

  // Pipeline registers; reset empties both stages at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s1_exp_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s1_exp_q   <= s1_exp_d;
      s2_valid_q <= s2_valid_d;
      s2_q       <= s2_d;
    end
  end

  assign bus.out_valid     = s2_valid_q;
  assign bus.out_result    = s2_q.result;
  assign bus.out_overflow  = s2_q.overflow;
  assign bus.out_underflow = s2_q.underflow;
  assign bus.out_exception = s2_q.exception;
`ifdef FP_ROUND_INEXACT_EN
  assign bus.out_inexact   = s2_q.inexact;
`endif

endmodule

// File: tb/tb_fp_mult_round.sv
// tb/tb_fp_mult_round.sv - self-checking bench for fp_mult_round
module tb_fp_mult_round;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_mult_round_if #(.EXP_W(10)) bus ();
  fp_mult_round #(.EXP_W(10)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] result;
    logic        ovf;
    logic        unf;
    logic        exc;
  } exp_t;

  typedef struct {
    logic        sign;
    int          e;
    logic [47:0] mant;
    logic [1:0]  cls;
    exp_t        want;
  } vec_t;

  vec_t vecs[$];
  exp_t q_exp[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic check_out(input string name, input exp_t w);
    check({name, " result"}, bus.out_result, w.result);
    check({name, " overflow"}, {31'd0, bus.out_overflow}, {31'd0, w.ovf});
    check({name, " underflow"}, {31'd0, bus.out_underflow}, {31'd0, w.unf});
    check({name, " exception"}, {31'd0, bus.out_exception}, {31'd0, w.exc});
  endtask

  // Reference: round the exact product value with remainder arithmetic.
  function automatic exp_t ref_model(input logic sign, input int e_in,
                                     input logic [47:0] mant, input logic [1:0] cls);
    exp_t r;
    longint unsigned m, q, rem, half;
    int e, drop;
    r.result = 32'd0; r.ovf = 1'b0; r.unf = 1'b0; r.exc = 1'b0;
    case (cls)
      2'b01: r.result = {sign, 31'd0};
      2'b10: begin r.result = {sign, 8'hFF, 23'd0}; r.exc = 1'b1; end
      2'b11: begin r.result = 32'h7FC00000; r.exc = 1'b1; end
      default: begin
        m = 64'(mant);
        e = e_in;
        drop = mant[47] ? 24 : 23;
        if (mant[47]) e = e + 1;
        q = m >> drop;
        rem = m - (q << drop);
        half = 64'd1 << (drop - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q >= (64'd1 << 24)) begin q = q >> 1; e = e + 1; end
        if (e >= 255) begin r.result = {sign, 8'hFF, 23'd0}; r.ovf = 1'b1; end
        else if (e <= 0) begin r.result = {sign, 31'd0}; r.unf = 1'b1; end
        else r.result = {sign, 8'(e), q[22:0]};
      end
    endcase
    return r;
  endfunction

  task automatic add_vec(input logic sign, input int e, input logic [47:0] mant, input logic [1:0] cls,
                         input logic [31:0] res, input logic ovf, input logic unf, input logic exc);
    vec_t v;
    v.sign = sign; v.e = e; v.mant = mant; v.cls = cls;
    v.want.result = res; v.want.ovf = ovf; v.want.unf = unf; v.want.exc = exc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic v, input logic sign, input int e, input logic [47:0] mant, input logic [1:0] cls);
    bus.in_valid = v;
    bus.in_sign  = sign;
    bus.in_exp   = 10'(e);
    bus.in_mant  = mant;
    bus.in_class = cls;
  endtask

  initial begin
    exp_t w;
    logic v, s;
    int e, stale;
    logic [1:0] c;
    logic [23:0] a, b;
    logic [47:0] m;

    add_vec(0, 127, 48'h9000_0000_0000, 2'b00, 32'h40100000, 0, 0, 0);
    add_vec(0, 127, 48'h4000_0040_0000, 2'b00, 32'h3F800000, 0, 0, 0);
    add_vec(0, 127, 48'h4000_00C0_0000, 2'b00, 32'h3F800002, 0, 0, 0);
    add_vec(0, 127, 48'h7FFF_FFFF_FFFF, 2'b00, 32'h40000000, 0, 0, 0);
    add_vec(0, 254, 48'h8000_0000_0000, 2'b00, 32'h7F800000, 1, 0, 0);
    add_vec(0, -5,  48'h4000_0000_0000, 2'b00, 32'h00000000, 0, 1, 0);
    add_vec(1, 127, 48'h4000_0000_0000, 2'b11, 32'h7FC00000, 0, 0, 1);
    add_vec(1, 127, 48'h4000_0000_0000, 2'b10, 32'hFF800000, 0, 0, 1);
    add_vec(1, 127, 48'h4000_0000_0000, 2'b01, 32'h80000000, 0, 0, 0);
    add_vec(0, 253, 48'hFFFF_FFFF_FFFF, 2'b00, 32'h7F800000, 1, 0, 0);
    add_vec(1, 254, 48'h4000_0000_0000, 2'b00, 32'hFF000000, 0, 0, 0);
    add_vec(0, 1,   48'h4000_0000_0000, 2'b00, 32'h00800000, 0, 0, 0);
    add_vec(0, 0,   48'h4000_0000_0000, 2'b00, 32'h00000000, 0, 1, 0);
    add_vec(0, 0,   48'h7FFF_FFFF_FFFF, 2'b00, 32'h00800000, 0, 0, 0);
    add_vec(1, -1,  48'h8000_0000_0000, 2'b00, 32'h80000000, 0, 1, 0);

    drive(0, 0, 0, 48'd0, 2'b00);
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("post-reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    w.result = 32'd0; w.ovf = 1'b0; w.unf = 1'b0; w.exc = 1'b0;
    check_out("post-reset", w);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(1, vecs[i].sign, vecs[i].e, vecs[i].mant, vecs[i].cls);
      #1 check($sformatf("vec%0d in_ready", i), {31'd0, bus.in_ready}, 32'd1);
      @(negedge clk);
      drive(0, 0, 0, 48'd0, 2'b00);
      #1 check($sformatf("vec%0d early out_valid", i), {31'd0, bus.out_valid}, 32'd0);
      @(negedge clk);
      #1 check($sformatf("vec%0d out_valid", i), {31'd0, bus.out_valid}, 32'd1);
      check_out($sformatf("vec%0d", i), vecs[i].want);
    end

    // Backpressure: three beats into a stalled pipe.
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      drive(1, vecs[k].sign, vecs[k].e, vecs[k].mant, vecs[k].cls);
      #1 check($sformatf("bp beat%0d in_ready", k), {31'd0, bus.in_ready}, (k < 2) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1 check("bp stall in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp stall out_valid", {31'd0, bus.out_valid}, 32'd1);
      check_out("bp stall hold", vecs[0].want);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1 check("bp release in_ready", {31'd0, bus.in_ready}, 32'd1);
    check_out("bp out0", vecs[0].want);
    @(negedge clk);
    drive(0, 0, 0, 48'd0, 2'b00);
    #1 check("bp out1 valid", {31'd0, bus.out_valid}, 32'd1);
    check_out("bp out1", vecs[1].want);
    @(negedge clk);
    #1 check("bp out2 valid", {31'd0, bus.out_valid}, 32'd1);
    check_out("bp out2", vecs[2].want);
    @(negedge clk);
    #1 check("bp drained", {31'd0, bus.out_valid}, 32'd0);

    // Reset in the middle of a full, stalled pipe.
    bus.out_ready = 1'b0;
    @(negedge clk);
    drive(1, vecs[3].sign, vecs[3].e, vecs[3].mant, vecs[3].cls);
    @(negedge clk);
    drive(1, vecs[4].sign, vecs[4].e, vecs[4].mant, vecs[4].cls);
    @(negedge clk);
    drive(0, 0, 0, 48'd0, 2'b00);
    #1 check("rst pipe full", {31'd0, bus.out_valid}, 32'd1);
    #1 rst = 1'b1;
    #1 check("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst out_result", bus.out_result, 32'd0);
    check("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      #1 if (bus.out_valid) stale++;
    end
    check("rst no stale beats", 32'(stale), 32'd0);

    // Random traffic with random backpressure against the reference model.
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      v = ($urandom_range(0, 3) != 0);
      s = 1'($urandom);
      e = int'($urandom_range(0, 320)) - 10;
      case ($urandom_range(0, 9))
        0: c = 2'b01;
        1: c = 2'b10;
        2: c = 2'b11;
        default: c = 2'b00;
      endcase
      a = {1'b1, 23'($urandom)};
      b = ($urandom_range(0, 7) == 0) ? 24'h800000 : {1'b1, 23'($urandom)};
      m = {24'd0, a} * {24'd0, b};
      drive(v, s, e, m, c);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        check("rand beat expected", {31'd0, q_exp.size() != 0}, 32'd1);
        if (q_exp.size() != 0) begin
          w = q_exp.pop_front();
          check_out("rand", w);
        end
      end
      if (bus.in_valid && bus.in_ready) q_exp.push_back(ref_model(s, e, m, c));
    end
    @(negedge clk);
    drive(0, 0, 0, 48'd0, 2'b00);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && q_exp.size() != 0; k++) begin
      #1;
      if (bus.out_valid) begin
        w = q_exp.pop_front();
        check_out("drain", w);
      end
      @(negedge clk);
    end
    check("rand all beats delivered", 32'(q_exp.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_mult_round.md
# fp_mult_round

Two-stage pipelined normalize-and-round stage placed directly downstream of the combinational single-precision multiplier core. It consumes the raw sign, widened exponent sum, 48-bit mantissa product and operand class, and produces a correctly rounded IEEE-754 binary32 result. Rounding is round-to-nearest-even, with overflow and underflow detected after rounding. A valid/ready handshake on both sides gives full throughput and backpressure.

## Interface
Parameters:
- `EXP_W`, 10: width of the signed biased exponent input, two's complement, holding exp_a + exp_b − 127.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  the input beat is valid.
- `in_ready`  out  1  the stage can accept the input beat.
- `in_sign`  in  1  product sign, a ^ b.
- `in_exp`  in  EXP_W  signed biased exponent sum.
- `in_mant`  in  48  product {1,frac_a} × {1,frac_b}.
- `in_class`  in  2  operand class: 00 normal, 01 zero, 10 infinity, 11 NaN.
- `out_valid`  out  1  the result is valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_result`  out  32  binary32 result.
- `out_overflow`  out  1  the rounded exponent is ≥ 255.
- `out_underflow`  out  1  the rounded exponent is ≤ 0.
- `out_exception`  out  1  the class is infinity or NaN.
- `out_inexact`  out  1  present only under `FP_ROUND_INEXACT_EN`.

## Operation
- Stage 1, normalize:
  - If `in_mant[47]` is set: frac = [46:24], guard = [23], sticky = |[22:0], exp = in_exp + 1.
  - Otherwise: frac = [45:23], guard = [22], sticky = |[21:0], exp = in_exp.
- Stage 2, round:
  - round_up = guard & (sticky | frac[0]).
  - {carry, frac} = frac + round_up. A carry sets frac = 0 and exp = exp + 1.
- Checks after rounding, normal class only, using the signed exponent:
  - exp ≥ 255: result {sign, 8'hFF, 0}, `out_overflow`=1.
  - exp ≤ 0: result {sign, 0, 0} (flush to zero), `out_underflow`=1.
- Class overrides, applied in place of the normal path:
  - Zero: {sign, 0, 0}, all flags 0.
  - Infinity: {sign, 8'hFF, 0}, `out_exception`=1.
  - NaN: 32'h7FC00000, `out_exception`=1.
- The class travels through both stages with its data.
- All arithmetic uses EXP_W-bit signed values. Exponents never truncate to 8 bits before the checks.

## Timing
- Latency is 2 cycles from input acceptance to `out_valid`, with `out_ready` held high. Throughput is 1 beat per cycle.
- An input transfers when `in_valid & in_ready`. An output transfers when `out_valid & out_ready`.
- A stage register loads when it is empty or its contents advance in the same cycle.
  - `in_ready` = !s1_valid | (s2 loads this cycle).
  - `in_ready` is combinational from `out_ready`.
- While `out_valid & !out_ready`, `out_result`, all flags and `out_valid` hold stable.
- When both stages are full and the output is stalled, `in_ready`=0. Capacity is exactly 2 beats.
- A simultaneous accept and emit on a full pipe shifts all beats, and no beat is lost.
- Reset values: all valid bits 0, `in_ready`=1 after reset release, `out_valid`=0, `out_result`=0, every flag 0.
- Reset asserted mid-operation discards all in-flight beats immediately.

## Configuration
- `FP_ROUND_INEXACT_EN` defined:
  - Port `out_inexact` exists.
  - It is 1 when guard | sticky on a normal result, on overflow, or on underflow with a nonzero mantissa.
  - It is 0 for class overrides.
  - Guard and sticky are carried in stage 2.
- `FP_ROUND_INEXACT_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `fp_pkg` holds:
  - the class enum `fp_class_t` (NORMAL, ZERO, INF, NAN);
  - the constants `FP_BIAS` = 127, `FP_EXP_MAX` = 255 and `FP_QNAN` = 32'h7FC00000;
  - the stage-register struct types.
- Sub-module `fp_round_rne` is combinational. It takes frac, guard, sticky and exp and returns the rounded frac, exp and inexact.

## Test plan
- 1.5×1.5: `in_mant`=48'h9000_0000_0000, `in_exp`=127, normal → `out_result`=32'h40100000 two cycles later, flags 0.
- Tie cases at `in_exp`=127:
  - `in_mant`=48'h4000_0040_0000 (lsb 0) → 32'h3F800000.
  - `in_mant`=48'h4000_00C0_0000 (lsb 1) → 32'h3F800002.
- Rounding carry: `in_mant`=48'h7FFF_FFFF_FFFF, `in_exp`=127 → 32'h40000000.
- Overflow and underflow:
  - `in_exp`=254, `in_mant`=48'h8000_0000_0000 → 32'h7F800000, `out_overflow`=1.
  - `in_exp`=−5 → 32'h00000000, `out_underflow`=1.
- Classes:
  - NaN, sign 1 → 32'h7FC00000, `out_exception`=1.
  - Infinity, sign 1 → 32'hFF800000, `out_exception`=1.
- Backpressure and reset:
  - Send 3 beats with `out_ready`=0 → `in_ready` drops after 2 beats. Releasing `out_ready` delivers all 3 in order.
  - Assert `rst` mid-stream → `out_valid`=0 at once, no stale beats afterwards.
